// File: rtl/tage_t0_if.sv
// TAGE T0 base-predictor bus: prediction lookup, update handshake and table RAM port.
// slave is the controller side; master is the environment (core, RAM).
interface tage_t0_if #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned PC_WIDTH   = 32
);
  logic                  pred_req;
  logic [PC_WIDTH-1:0]   pred_pc;
  logic                  pred_vld;
  logic                  pred_taken;
  logic [1:0]            pred_ctr;

  logic                  upd_valid;
  logic                  upd_ready;
  logic [PC_WIDTH-1:0]   upd_pc;
  logic                  upd_taken;
  logic [1:0]            upd_ctr;

  logic                  init_done;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [1:0]            ram_wdata;
  logic [1:0]            ram_q;

  modport slave (
    input  pred_req, pred_pc, upd_valid, upd_pc, upd_taken, upd_ctr, ram_q,
    output pred_vld, pred_taken, pred_ctr, upd_ready, init_done,
           ram_we, ram_waddr, ram_raddr, ram_wdata
  );

  modport master (
    output pred_req, pred_pc, upd_valid, upd_pc, upd_taken, upd_ctr, ram_q,
    input  pred_vld, pred_taken, pred_ctr, upd_ready, init_done,
           ram_we, ram_waddr, ram_raddr, ram_wdata
  );
endinterface

// File: rtl/tage_t0_ctrl.sv
// TAGE T0 bimodal table controller: lookup with write bypass, saturating-counter updates.
// Define TAGE_T0_INIT_SWEEP_EN to sweep the table to 2'b01 after reset; otherwise RAM preload is used.
module tage_t0_ctrl #(
  parameter int unsigned NUM_ENTRIES = 512,
  parameter int unsigned ADDR_WIDTH  = $clog2(NUM_ENTRIES),
  parameter int unsigned PC_WIDTH    = 32
) (
  input logic       clk,
  input logic       rst_n,
  tage_t0_if.slave  bus
);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e                state_q, state_d;
  logic                  init_done_q;
  logic                  pred_vld_q;
  logic                  byp_hit_q;
  logic [1:0]            byp_data_q;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_waddr_q, ram_waddr_d;
  logic [1:0]            ram_wdata_q, ram_wdata_d;

  logic [ADDR_WIDTH-1:0] pred_idx;
  logic [ADDR_WIDTH-1:0] upd_idx;
  logic                  upd_acc;
  logic [1:0]            base_ctr;
  logic [1:0]            new_ctr;
  logic [1:0]            pred_ctr;

`ifdef TAGE_T0_INIT_SWEEP_EN
  localparam logic [ADDR_WIDTH:0] SweepEnd = (ADDR_WIDTH+1)'(NUM_ENTRIES);
  localparam state_e              StReset  = StInit;
  logic [ADDR_WIDTH:0] sweep_q, sweep_d;
`else
  localparam state_e              StReset  = StRun;
`endif

  logic unused_pc;
  assign unused_pc = ^{bus.pred_pc[PC_WIDTH-1:ADDR_WIDTH+2], bus.pred_pc[1:0],
                       bus.upd_pc[PC_WIDTH-1:ADDR_WIDTH+2], bus.upd_pc[1:0]};

  assign pred_idx      = bus.pred_pc[ADDR_WIDTH+1:2];
  assign upd_idx       = bus.upd_pc[ADDR_WIDTH+1:2];
  assign upd_acc       = bus.upd_valid & init_done_q;
  assign bus.ram_raddr = pred_idx;

  // Base counter forwards the write in flight so back-to-back updates chain correctly.
  always_comb begin
    base_ctr = (ram_we_q && (ram_waddr_q == upd_idx)) ? ram_wdata_q : bus.upd_ctr;
    new_ctr  = base_ctr;
    if (bus.upd_taken) begin
      if (base_ctr != 2'b11) new_ctr = base_ctr + 2'd1;
    end else begin
      if (base_ctr != 2'b00) new_ctr = base_ctr - 2'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    ram_we_d    = 1'b0;
    ram_waddr_d = ram_waddr_q;
    ram_wdata_d = ram_wdata_q;
`ifdef TAGE_T0_INIT_SWEEP_EN
    sweep_d     = sweep_q;
`endif
    unique case (state_q)
      StInit: begin
`ifdef TAGE_T0_INIT_SWEEP_EN
        if (sweep_q == SweepEnd) begin
          state_d = StRun;
        end else begin
          ram_we_d    = 1'b1;
          ram_waddr_d = sweep_q[ADDR_WIDTH-1:0];
          ram_wdata_d = 2'b01;
          sweep_d     = sweep_q + (ADDR_WIDTH+1)'(1);
        end
`else
        state_d = StRun;
`endif
      end
      StRun: begin
        // Saturated updates are consumed without touching the RAM.
        if (upd_acc && (new_ctr != base_ctr)) begin
          ram_we_d    = 1'b1;
          ram_waddr_d = upd_idx;
          ram_wdata_d = new_ctr;
        end
      end
      default: state_d = StReset;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StReset;
      init_done_q <= 1'b0;
      pred_vld_q  <= 1'b0;
      byp_hit_q   <= 1'b0;
      byp_data_q  <= 2'b00;
      ram_we_q    <= 1'b0;
      ram_waddr_q <= '0;
      ram_wdata_q <= 2'b00;
`ifdef TAGE_T0_INIT_SWEEP_EN
      sweep_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      init_done_q <= (state_d == StRun);
      pred_vld_q  <= bus.pred_req & init_done_q;
      byp_hit_q   <= ram_we_q && (ram_waddr_q == pred_idx);
      byp_data_q  <= ram_wdata_q;
      ram_we_q    <= ram_we_d;
      ram_waddr_q <= ram_waddr_d;
      ram_wdata_q <= ram_wdata_d;
`ifdef TAGE_T0_INIT_SWEEP_EN
      sweep_q     <= sweep_d;
`endif
    end
  end

  // The RAM returns old data on a same-cycle collision, so the bypass overrides it.
  always_comb begin
    pred_ctr = 2'b00;
    if (pred_vld_q) pred_ctr = byp_hit_q ? byp_data_q : bus.ram_q;
  end

  assign bus.pred_vld   = pred_vld_q;
  assign bus.pred_ctr   = pred_ctr;
  assign bus.pred_taken = pred_ctr[1];
  assign bus.upd_ready  = init_done_q;
  assign bus.init_done  = init_done_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_waddr  = ram_waddr_q;
  assign bus.ram_wdata  = ram_wdata_q;

endmodule

// File: tb/tb_tage_t0_ctrl.sv
// Directed bench for tage_t0_ctrl with a behavioural 1-cycle-latency table RAM.
module tb_tage_t0_ctrl;
  localparam int unsigned NumEntries = 512;
  localparam int unsigned AddrWidth  = 9;
  localparam int unsigned PcWidth    = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [1:0] mem [NumEntries];

  tage_t0_if #(.ADDR_WIDTH(AddrWidth), .PC_WIDTH(PcWidth)) bus ();

  tage_t0_ctrl #(
    .NUM_ENTRIES(NumEntries),
    .ADDR_WIDTH (AddrWidth),
    .PC_WIDTH   (PcWidth)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Read-before-write RAM: a same-cycle read of the written address sees old data.
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
    bus.ram_q <= mem[bus.ram_raddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic t, input logic [1:0] c);
    bus.upd_valid = v;
    bus.upd_pc    = pc;
    bus.upd_taken = t;
    bus.upd_ctr   = c;
  endtask

  initial begin
    for (int i = 0; i < int'(NumEntries); i++) begin
`ifdef TAGE_T0_INIT_SWEEP_EN
      mem[i] = 2'b00;
`else
      mem[i] = 2'b01;
`endif
    end
    rst_n        = 1'b0;
    bus.ram_q    = 2'b00;
    bus.pred_req = 1'b0;
    bus.pred_pc  = '0;
    set_upd(1'b0, 32'h0, 1'b0, 2'b00);

    step();
    step();
    chk("rst_init_done", bus.init_done, 0);
    chk("rst_pred_vld",  bus.pred_vld, 0);
    chk("rst_pred_ctr",  bus.pred_ctr, 0);
    chk("rst_pred_taken", bus.pred_taken, 0);
    chk("rst_ram_we",    bus.ram_we, 0);
    chk("rst_upd_ready", bus.upd_ready, 0);

    rst_n = 1'b1;
`ifdef TAGE_T0_INIT_SWEEP_EN
    // Lookups during the sweep must be ignored.
    bus.pred_req = 1'b1;
    for (int i = 0; i < int'(NumEntries); i++) begin
      logic [8:0] idx;
      idx = i[8:0];
      step();
      chk("sweep_write", {bus.pred_vld, bus.upd_ready, bus.init_done, bus.ram_we,
                          bus.ram_waddr, bus.ram_wdata},
          {1'b0, 1'b0, 1'b0, 1'b1, idx, 2'b01});
    end
    bus.pred_req = 1'b0;
    step();
`else
    step();
`endif
    chk("init_done_up",   bus.init_done, 1);
    chk("init_ram_we",    bus.ram_we, 0);
    chk("init_upd_ready", bus.upd_ready, 1);
    step();

    // Plain lookup of 0x100.
    bus.pred_req = 1'b1;
    bus.pred_pc  = 32'h100;
    #1;
    chk("lookup_raddr", bus.ram_raddr, 9'h040);
    step();
    bus.pred_req = 1'b0;
    chk("lookup_vld",   bus.pred_vld, 1);
    chk("lookup_ctr",   bus.pred_ctr, 2'b01);
    chk("lookup_taken", bus.pred_taken, 0);

    // Update then same-index lookup while the write is in flight.
    set_upd(1'b1, 32'h100, 1'b1, 2'b01);
    step();
    set_upd(1'b0, 32'h0, 1'b0, 2'b00);
    bus.pred_req = 1'b1;
    bus.pred_pc  = 32'h100;
    chk("upd_we",    bus.ram_we, 1);
    chk("upd_waddr", bus.ram_waddr, 9'h040);
    chk("upd_wdata", bus.ram_wdata, 2'b10);
    step();
    bus.pred_req = 1'b0;
    chk("byp_vld",   bus.pred_vld, 1);
    chk("byp_ctr",   bus.pred_ctr, 2'b10);
    chk("byp_taken", bus.pred_taken, 1);
    chk("byp_no_we", bus.ram_we, 0);

    // Saturation at both ends suppresses the write.
    set_upd(1'b1, 32'h200, 1'b1, 2'b11);
    step();
    chk("sat_hi_we", bus.ram_we, 0);
    set_upd(1'b1, 32'h204, 1'b0, 2'b00);
    step();
    chk("sat_lo_we", bus.ram_we, 0);
    set_upd(1'b1, 32'h204, 1'b0, 2'b10);
    step();
    set_upd(1'b0, 32'h0, 1'b0, 2'b00);
    chk("dec_we_wdata_waddr", {bus.ram_we, bus.ram_wdata, bus.ram_waddr},
        {1'b1, 2'b01, 9'h081});
    step();

    // Back-to-back updates chain through the in-flight write.
    set_upd(1'b1, 32'h100, 1'b1, 2'b01);
    step();
    chk("b2b_first", {bus.ram_we, bus.ram_waddr, bus.ram_wdata}, {1'b1, 9'h040, 2'b10});
    step();
    set_upd(1'b0, 32'h0, 1'b0, 2'b00);
    chk("b2b_second", {bus.ram_we, bus.ram_waddr, bus.ram_wdata}, {1'b1, 9'h040, 2'b11});
    step();
    chk("b2b_idle_we", bus.ram_we, 0);
    bus.pred_req = 1'b1;
    bus.pred_pc  = 32'h100;
    step();
    bus.pred_req = 1'b0;
    chk("b2b_readback", bus.pred_ctr, 2'b11);

    // Reset lands between acceptance and the write edge.
    set_upd(1'b1, 32'h300, 1'b1, 2'b01);
    step();
    set_upd(1'b0, 32'h0, 1'b0, 2'b00);
    chk("pend_we", {bus.ram_we, bus.ram_waddr}, {1'b1, 9'h0c0});
    #2;
    rst_n = 1'b0;
    #1;
    chk("pend_rst_we",        bus.ram_we, 0);
    chk("pend_rst_init_done", bus.init_done, 0);
    step();
    chk("pend_no_write", mem[192], 2'b01);
    step();
    rst_n = 1'b1;
    step();
`ifdef TAGE_T0_INIT_SWEEP_EN
    chk("resweep_0", {bus.init_done, bus.ram_we, bus.ram_waddr, bus.ram_wdata},
        {1'b0, 1'b1, 9'h000, 2'b01});
    step();
    chk("resweep_1", {bus.init_done, bus.ram_we, bus.ram_waddr, bus.ram_wdata},
        {1'b0, 1'b1, 9'h001, 2'b01});
`else
    chk("rerun_init_done", bus.init_done, 1);
    chk("rerun_we",        bus.ram_we, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
